// File: rtl/bs2pol_pkg.sv
// Shared constants, FSM state type and lane extension for the bs2polvec unpacker.
// Build macro BS2POL_SIGN_EXT_EN selects sign-extension of each lane instead of zero-extension.
package bs2pol_pkg;
    localparam int N_COEF = 256;
    localparam int WORD_W = 64;
    localparam int LANE_W = 16;
    localparam int BUF_W  = 192;

    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

    function automatic logic [LANE_W-1:0] lane_ext(input logic [LANE_W-1:0] raw,
                                                   input int unsigned       w);
        logic [LANE_W-1:0] mask;
        logic [LANE_W-1:0] res;
        // low w bits set; a shift of LANE_W or more yields an all-ones mask
        mask = ~({LANE_W{1'b1}} << w);
        res  = raw & mask;
`ifdef BS2POL_SIGN_EXT_EN
        if (|(raw & mask & ~(mask >> 1)))
            res = res | ~mask;
`endif
        return res;
    endfunction
endpackage

// File: rtl/bs2pol_gearbox.sv
// Gearbox: 192-bit buffer emitting EMIT_W-bit chunks from the LSB end and landing
// 64-bit read words at the post-emit fill position, both in the same cycle if needed.
module bs2pol_gearbox
    import bs2pol_pkg::*;
#(
    parameter int EMIT_W = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              land,
    input  logic [WORD_W-1:0] land_data,
    output logic              emit,
    output logic [EMIT_W-1:0] chunk,
    output logic              can_read
);
    localparam int FILL_W = $clog2(BUF_W + 1);

    logic [BUF_W-1:0]  buf_q;
    logic [BUF_W-1:0]  buf_post;
    logic [BUF_W-1:0]  buf_nxt;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_post;
    logic [FILL_W-1:0] fill_nxt;

    always_comb begin
        emit      = fill_q >= FILL_W'(EMIT_W);
        buf_post  = emit ? (buf_q >> EMIT_W) : buf_q;
        fill_post = emit ? (fill_q - FILL_W'(EMIT_W)) : fill_q;
        buf_nxt   = land ? (buf_post | (BUF_W'(land_data) << fill_post)) : buf_post;
        fill_nxt  = land ? (fill_post + FILL_W'(WORD_W)) : fill_post;
        // a read issued now lands next cycle, on top of whatever lands this cycle
        can_read  = ({1'b0, fill_post} + (land ? (FILL_W+1)'(WORD_W) : '0)
                     + (FILL_W+1)'(WORD_W)) <= (FILL_W+1)'(BUF_W);
    end

    assign chunk = buf_q[EMIT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q  <= '0;
            fill_q <= '0;
        end else if (clr) begin
            buf_q  <= '0;
            fill_q <= '0;
        end else begin
            buf_q  <= buf_nxt;
            fill_q <= fill_nxt;
        end
    end
endmodule

// File: rtl/bs2polvec_unpack.sv
// Byte-string to polynomial-vector unpacker: streams NUM_POLY x 256 COEF_W-bit coefficients
// into 16-bit lanes, 4 per 64-bit word. Lane extension set by BS2POL_SIGN_EXT_EN.
//   state | meaning
//   IDLE  | after reset, waiting for start
//   FILL  | reads issued, buffer not yet holding a full output word
//   RUN   | writing one word per cycle until the last write
//   DONE  | image complete, done high, waiting for start
module bs2polvec_unpack
    import bs2pol_pkg::*;
#(
    parameter int COEF_W   = 10,
    parameter int NUM_POLY = 3,
    parameter int ADDR_W   = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [ADDR_W-1:0] wr_base,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [63:0]       rd_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_en,
    output logic [63:0]       wr_data,
    output logic              busy,
    output logic              done
);
    localparam int EMIT_W    = 4 * COEF_W;
    localparam int IN_WORDS  = 4 * COEF_W * NUM_POLY;
    localparam int OUT_WORDS = (N_COEF / 4) * NUM_POLY;
    localparam int CNT_W     = $clog2(N_COEF + 1);

    state_t            state;
    state_t            state_nxt;
    logic              go;
    logic              active;
    logic              last_wr;
    logic              rd_pend;
    logic              emit;
    logic              can_read;
    logic [EMIT_W-1:0] chunk;
    logic [CNT_W-1:0]  rd_left;
    logic [CNT_W-1:0]  wr_left;

    bs2pol_gearbox #(.EMIT_W(EMIT_W)) u_gearbox (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (go),
        .land      (rd_pend),
        .land_data (rd_data),
        .emit      (emit),
        .chunk     (chunk),
        .can_read  (can_read)
    );

    assign go      = start && (state == IDLE || state == DONE);
    assign active  = (state == FILL) || (state == RUN);
    assign rd_en   = active && (rd_left != '0) && can_read;
    assign wr_en   = active && emit;
    assign last_wr = wr_en && (wr_left == CNT_W'(1));
    assign busy    = active;
    assign done    = (state == DONE);

    always_comb begin
        wr_data = '0;
        if (wr_en) begin
            for (int j = 0; j < 4; j++)
                wr_data[j*LANE_W +: LANE_W] = lane_ext(LANE_W'(chunk[j*COEF_W +: COEF_W]), COEF_W);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start)   state_nxt = FILL;
            FILL:       if (emit)    state_nxt = RUN;
            RUN:        if (last_wr) state_nxt = DONE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_left <= '0;
            wr_left <= '0;
            rd_addr <= '0;
            wr_addr <= '0;
            rd_pend <= 1'b0;
        end else if (go) begin
            rd_left <= CNT_W'(IN_WORDS);
            wr_left <= CNT_W'(OUT_WORDS);
            rd_addr <= rd_base;
            wr_addr <= wr_base;
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= rd_en;
            if (rd_en) begin
                rd_left <= rd_left - CNT_W'(1);
                rd_addr <= rd_addr + ADDR_W'(1);
            end
            if (wr_en) begin
                wr_left <= wr_left - CNT_W'(1);
                wr_addr <= wr_addr + ADDR_W'(1);
            end
        end
    end
endmodule
